// File: rtl/fp_result_retire_if.sv
// Handshake and status bundle for fp_result_retire.
// master = FMA producer / consumer side, slave = the retire queue.
interface fp_result_retire_if #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23,
  parameter int unsigned depth      = 4
);
  localparam int unsigned ResultW = exp_width + frac_width + 1;
  localparam int unsigned CountW  = $clog2(depth) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [ResultW-1:0] in_result;
  logic [4:0]         in_exception;
  logic [3:0]         in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [ResultW-1:0] out_result;
  logic [4:0]         out_exception;
  logic [3:0]         out_tag;
  logic               flags_clear;
  logic [4:0]         flags;
  logic [CountW-1:0]  count;

  modport master (
    output in_valid, in_result, in_exception, in_tag, out_ready, flags_clear,
    input  in_ready, out_valid, out_result, out_exception, out_tag, flags, count
  );

  modport slave (
    input  in_valid, in_result, in_exception, in_tag, out_ready, flags_clear,
    output in_ready, out_valid, out_result, out_exception, out_tag, flags, count
  );
endinterface

// File: rtl/fp_result_retire.sv
// In-order retire queue for FMA results with sticky accrued exception flags.
// Optional macro FP_RESULT_NAN_CANON_EN canonicalises stored NaNs to the default qNaN.
module fp_result_retire #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23,
  parameter int unsigned depth      = 4
) (
  input logic                 clk,
  input logic                 reset,
  fp_result_retire_if.slave   bus
);
  localparam int unsigned ResultW = exp_width + frac_width + 1;
  localparam int unsigned PtrW    = $clog2(depth);
  localparam int unsigned CountW  = PtrW + 1;
  localparam int unsigned EntryW  = ResultW + 5 + 4;
  localparam logic [CountW-1:0] Full = CountW'(depth);

  logic [EntryW-1:0]  r_mem [depth];
  logic [PtrW-1:0]    r_wptr;
  logic [PtrW-1:0]    r_rptr;
  logic [CountW-1:0]  r_count;
  logic [4:0]         r_flags;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [ResultW-1:0] w_store;
  logic [EntryW-1:0]  w_head;

  // in_ready looks only at occupancy, so a pop never frees a slot in the same cycle.
  assign w_in_ready  = (r_count != Full);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

`ifdef FP_RESULT_NAN_CANON_EN
  logic w_is_nan;
  assign w_is_nan = (&bus.in_result[ResultW-2 -: exp_width]) &&
                    (bus.in_result[frac_width-1:0] != '0);
  assign w_store  = w_is_nan ? {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}}
                             : bus.in_result;
`else
  assign w_store  = bus.in_result;
`endif

  // Storage is left unreset; it is only observable once count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_store, bus.in_exception, bus.in_tag};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_flags <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_flags <= (bus.flags_clear ? 5'b0 : r_flags) | (w_pop ? w_head[8:4] : 5'b0);
    end
  end

  assign w_head            = r_mem[r_rptr];
  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_result    = w_head[EntryW-1:9];
  assign bus.out_exception = w_head[8:4];
  assign bus.out_tag       = w_head[3:0];
  assign bus.flags         = r_flags;
  assign bus.count         = r_count;
endmodule

// File: doc/fp_result_retire.md
FP_RESULT_RETIRE -- requirements
Module: fp_result_retire

Interface
REQ-001 Parameter exp_width, default 8, exponent field width of the carried float.
REQ-002 Parameter frac_width, default 23, fraction field width of the carried float.
REQ-003 Parameter depth, default 4, result queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  FMA stage presents a result this cycle.
REQ-007 in_ready  output  1  block accepts in_* this cycle.
REQ-008 in_result  input  exp_width+frac_width+1  packed sign/exp/frac from FMA.
REQ-009 in_exception  input  5  FMA flags, FP_* bit positions from FloatingPointConsts.
REQ-010 in_tag  input  4  destination/ordering tag, carried unchanged.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_result  output  exp_width+frac_width+1  head result.
REQ-014 out_exception  output  5  head entry flags.
REQ-015 out_tag  output  4  head entry tag.
REQ-016 flags_clear  input  1  clear accrued flags.
REQ-017 flags  output  5  sticky accrued exception flags (fflags-style).
REQ-018 count  output  $clog2(depth)+1  current occupancy.

Function
REQ-019 Push SHALL occur iff in_valid && in_ready; pop iff out_valid && out_ready.
REQ-020 in_ready SHALL equal (count != depth); no combinational dependence on out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_result/out_exception/out_tag SHALL come from the entry at the read pointer and stay stable while out_valid && !out_ready.
REQ-022 Latency: entry pushed in cycle N SHALL be visible on out_* in cycle N+1 at earliest; no fall-through, no bypass.
REQ-023 Entries SHALL retire in strict push order; tags SHALL NOT be reordered or altered.
REQ-024 Read/write pointers SHALL wrap modulo depth; count SHALL be unchanged on simultaneous push and pop, +1 on push only, -1 on pop only.
REQ-025 When full, in_ready=0 even if a pop occurs that cycle; the freed slot becomes available next cycle.
REQ-026 flags SHALL accrue at pop: next flags = (flags_clear ? 0 : flags) | (pop ? out_exception : 0).
REQ-027 flags_clear coincident with pop SHALL leave exactly the popped entry's exception bits set.
REQ-028 flags SHALL NOT change on push, only on pop or clear.
REQ-029 A pop with out_exception == 0 SHALL leave flags unchanged unless flags_clear.

Reset
REQ-030 reset SHALL immediately force count=0, pointers=0, flags=0, out_valid=0, in_ready=1.
REQ-031 reset asserted mid-operation SHALL discard all queued entries; no pop and no flag accrual for them.
REQ-032 Storage array contents are don't-care after reset; out_result/out_exception/out_tag are don't-care while out_valid=0.
REQ-033 First push SHALL be accepted in the first rising edge after reset deasserts.

Configuration
REQ-034 Macro FP_RESULT_NAN_CANON_EN defined: any pushed in_result with exponent all-ones and non-zero fraction SHALL be stored as canonical qNaN {0, all-ones exp, 1, zeros}; other values and all exception bits SHALL be unaltered.
REQ-035 FP_RESULT_NAN_CANON_EN undefined: in_result SHALL be stored bit-exact, including NaN sign and payload.

Verification
REQ-036 Reset, push 1 entry (result 0x3F800000, exc 0, tag 3), out_ready=1 -> out_valid=1 the next cycle with 0x3F800000, tag 3; count returns to 0 after pop.
REQ-037 out_ready=0, push 4 entries with tags 0..3 -> count=4, in_ready=0, 5th in_valid stalled; then out_ready=1 -> tags popped 0,1,2,3 in order.
REQ-038 Full queue, push and pop in same cycle -> push refused, count 4 to 3, in_ready=1 the next cycle.
REQ-039 Pop entries with exception overflow, then inexact -> flags = overflow|inexact; flags_clear with pop of underflow entry -> flags = underflow only.
REQ-040 Assert reset with 3 entries queued -> out_valid=0, count=0, flags=0 asynchronously; no tag from before reset ever appears on out_tag.
REQ-041 Push 0xFFC12345 -> out_result 0x7FC00000 with FP_RESULT_NAN_CANON_EN defined, 0xFFC12345 without.
